// File: rtl/sec_count_ctrl.sv
// Seconds count source: debounced run/stop button, prescaled up/down 0..MAX_COUNT counter with load.
// Define SEC_COUNT_SATURATE_EN to hold at the terminal value and auto-stop instead of wrapping.
module sec_count_ctrl #(
    parameter int CLK_DIV    = 50_000_000,
    parameter int MAX_COUNT  = 59,
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_run,
    input  logic       up_dn,
    input  logic       load,
    input  logic [5:0] load_val,
    output logic [5:0] count,
    output logic       carry,
    output logic       running,
    output logic       tick
);
    localparam int PW = $clog2(CLK_DIV);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [5:0]    MAX_VAL  = 6'(MAX_COUNT);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t        state, state_nxt;
    logic          sync1, sync2, deb, deb_d, press;
    logic [DW-1:0] deb_cnt;
    logic [PW-1:0] presc;
    logic [5:0]    count_nxt;
    logic          carry_nxt, sat_stop, tick_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            deb     <= 1'b0;
            deb_d   <= 1'b0;
            deb_cnt <= '0;
        end else begin
            sync1 <= btn_run;
            sync2 <= sync1;
            deb_d <= deb;
            if (sync2 == deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb     <= sync2;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    // Only the press (rising debounced edge) toggles run/stop; releases are ignored.
    assign press   = deb & ~deb_d;
    assign running = (state == RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (press)    state_nxt = (state == IDLE) ? RUN : IDLE;
        if (sat_stop) state_nxt = IDLE;
    end

    always_comb begin
        count_nxt = count;
        carry_nxt = 1'b0;
        sat_stop  = 1'b0;
        if (load) begin
            count_nxt = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (tick) begin
            if (up_dn) begin
                if (count == MAX_VAL) begin
                    carry_nxt = 1'b1;
`ifdef SEC_COUNT_SATURATE_EN
                    sat_stop  = 1'b1;
`else
                    count_nxt = '0;
`endif
                end else begin
                    count_nxt = count + 6'd1;
                end
            end else begin
                if (count == 6'd0) begin
                    carry_nxt = 1'b1;
`ifdef SEC_COUNT_SATURATE_EN
                    sat_stop  = 1'b1;
`else
                    count_nxt = MAX_VAL;
`endif
                end else begin
                    count_nxt = count - 6'd1;
                end
            end
        end
    end

    // A wrap on the edge that leaves RUN, or that a load restarts, must not emit a tick.
    assign tick_nxt = (state == RUN) && (presc == PRE_LAST) && !load && (state_nxt == RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
            tick  <= 1'b0;
            count <= '0;
            carry <= 1'b0;
        end else begin
            tick  <= tick_nxt;
            count <= count_nxt;
            carry <= carry_nxt;
            if (load)
                presc <= '0;
            else if (state == RUN)
                presc <= (presc == PRE_LAST) ? '0 : presc + 1'b1;
        end
    end
endmodule

// File: tb/tb_sec_count_ctrl.sv
// Directed bench for sec_count_ctrl (CLK_DIV=4, MAX_COUNT=59, DEB_CYCLES=3) with a count/carry scoreboard.
module tb_sec_count_ctrl;
    logic       clk = 1'b0;
    logic       reset, btn_run, up_dn, load;
    logic [5:0] load_val;
    logic [5:0] count;
    logic       carry, running, tick;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int cnt;
        int cy;
    } exp_t;
    exp_t q[$];
    logic [5:0] prev_count = '0;

    sec_count_ctrl #(.CLK_DIV(4), .MAX_COUNT(59), .DEB_CYCLES(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_run  (btn_run),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .carry    (carry),
        .running  (running),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d, required %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int c, input int cy);
        exp_t e;
        e.cnt = c;
        e.cy  = cy;
        q.push_back(e);
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Button held 6 cycles: the state toggles on the 6th edge, when this returns.
    task automatic press_hold();
        btn_run = 1'b1;
        repeat (6) cyc();
        btn_run = 1'b0;
    endtask

    // Every count change or carry pulse must match the next expected entry.
    always @(negedge clk) begin
        if (count !== prev_count || carry === 1'b1) begin
            tests++;
            assert (q.size() > 0) else begin
                fails++;
                $error("FAIL sb_unexpected: got count=%0d carry=%0b, required no event", count, carry);
            end
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                chk("sb_count", int'(count), e.cnt);
                chk("sb_carry", int'(carry), e.cy);
            end
        end
        prev_count <= count;
    end

    initial begin
        reset = 1'b1; btn_run = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0;
        cyc(); cyc();
        chk("rst_count", int'(count), 0);
        chk("rst_carry", int'(carry), 0);
        chk("rst_running", int'(running), 0);
        chk("rst_tick", int'(tick), 0);
        reset = 1'b0;
        cyc();

        // Start: running after 2 sync + 3 debounce + 1 state cycles, first tick 4 cycles later.
        btn_run = 1'b1;
        push(1, 0);
        for (int i = 1; i <= 11; i++) begin
            cyc();
            if (i == 5) chk("run_early", int'(running), 0);
            if (i == 6) chk("run_on", int'(running), 1);
            if (i == 8) btn_run = 1'b0;
            if (i == 9) chk("tick_early", int'(tick), 0);
            if (i == 10) begin
                chk("tick_first", int'(tick), 1);
                chk("count_before_tick", int'(count), 0);
            end
            if (i == 11) chk("count_first", int'(count), 1);
        end
        push(2, 0);
        push(3, 0);
        cyc(); cyc();
        press_hold();
        chk("stop_with_tick_count", int'(count), 3);
        chk("stop_running", int'(running), 0);
        repeat (6) cyc();

        // Bounce: short pulses never reach the debounce threshold.
        for (int k = 0; k < 3; k++) begin
            btn_run = 1'b1; cyc(); cyc();
            btn_run = 1'b0; cyc(); cyc();
            chk("bounce_running", int'(running), 0);
            chk("bounce_tick", int'(tick), 0);
        end
        repeat (4) cyc();
        chk("bounce_final", int'(running), 0);

        // Up-count wrap 59 -> 0 with a single carry pulse.
        load_val = 6'd58; load = 1'b1; push(58, 0);
        cyc();
        load = 1'b0; up_dn = 1'b1;
        chk("load_58", int'(count), 58);
        push(59, 0);
        push(0, 1);
        press_hold();
        repeat (5) cyc();
        chk("up_59", int'(count), 59);
        repeat (3) cyc();
        chk("carry_before_wrap", int'(carry), 0);
        cyc();
        chk("wrap_count", int'(count), 0);
        chk("wrap_carry", int'(carry), 1);
        cyc();
        chk("carry_one_cycle", int'(carry), 0);
        push(1, 0);
        press_hold();
        chk("stop2_running", int'(running), 0);
        chk("stop2_count", int'(count), 1);
        repeat (6) cyc();

        // Down-count from 0.
        load_val = 6'd0; up_dn = 1'b0; load = 1'b1; push(0, 0);
        cyc();
        load = 1'b0;
        chk("load_0", int'(count), 0);
`ifdef SEC_COUNT_SATURATE_EN
        push(0, 1);
        press_hold();
        repeat (5) cyc();
        chk("sat_count", int'(count), 0);
        chk("sat_carry", int'(carry), 1);
        chk("sat_running", int'(running), 0);
        repeat (6) cyc();
        chk("sat_stays_idle", int'(running), 0);
`else
        push(59, 1);
        push(58, 0);
        press_hold();
        repeat (5) cyc();
        chk("down_wrap_count", int'(count), 59);
        chk("down_wrap_carry", int'(carry), 1);
        chk("down_wrap_running", int'(running), 1);
        press_hold();
        chk("stop3_count", int'(count), 58);
        chk("stop3_running", int'(running), 0);
        repeat (6) cyc();
`endif

        // Load clamps to MAX_COUNT; mid-period load restarts the prescaler.
        load_val = 6'd63; load = 1'b1; up_dn = 1'b1; push(59, 0);
        cyc();
        load = 1'b0;
        chk("load_clamp", int'(count), 59);
        press_hold();
        cyc(); cyc();
        load_val = 6'd12; load = 1'b1; push(12, 0);
        cyc();
        load = 1'b0;
        chk("load_12", int'(count), 12);
        chk("load_keeps_run", int'(running), 1);
        push(13, 0);
        repeat (3) cyc();
        chk("tick_after_load_early", int'(tick), 0);
        cyc();
        chk("tick_after_load", int'(tick), 1);
        cyc();
        chk("count_13", int'(count), 13);

        // Asynchronous reset while running at 37.
        load_val = 6'd37; load = 1'b1; push(37, 0);
        cyc();
        load = 1'b0;
        chk("load_37", int'(count), 37);
        chk("run_at_37", int'(running), 1);
        push(0, 0);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_count", int'(count), 0);
        chk("async_rst_running", int'(running), 0);
        chk("async_rst_carry", int'(carry), 0);
        chk("async_rst_tick", int'(tick), 0);
        cyc();
        reset = 1'b0;
        repeat (3) cyc();
        chk("sb_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
